bnn_feature_loader: RTL

BNN_FEATURE_LOADER -- requirements
Module: bnn_feature_loader

---
 rtl/bnn_feature_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/bnn_feature_loader.sv
// Feature-frame loader for a combinational BNN classifier: collects beats into a
// feature vector, waits for the classifier to settle, then holds the result until taken.
module bnn_feature_loader #(
  parameter int FEAT_CNT      = 16,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 10,
  parameter int SETTLE_CYCLES = 2,
  localparam int CLS_BITS     = $clog2(CLASS_CNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_data,
  input  logic                          in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [CLS_BITS-1:0]           prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CLS_BITS-1:0]           out_class,
  output logic                          out_err
);

  localparam int CNT_W = $clog2(FEAT_CNT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(FEAT_CNT - 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {LOAD, DRAIN, SETTLE, DONE} state_t;

  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              cnt;
  logic [7:0]                    settle_cnt;
  logic                          err;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_p0;
  logic [CLS_BITS-1:0]           class_p1;
  logic                          err_p1;
  logic                          vld_p1;
  logic                          beat;
  logic                          settle_done;
  logic                          release_res;

  assign in_ready    = (state == LOAD) || (state == DRAIN);
  assign beat        = in_valid && in_ready;
  assign settle_done = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
  assign release_res = (state == DONE) && out_ready;
  assign vld_p1      = (state == DONE);

  assign features  = feat_p0;
  assign out_valid = vld_p1;
  assign out_class = class_p1;
  assign out_err   = err_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (beat) begin
          if (in_last)               state_nxt = SETTLE;
          else if (cnt == LAST_IDX)  state_nxt = DRAIN;
        end
      end
      DRAIN:   if (beat && in_last) state_nxt = SETTLE;
      SETTLE:  if (settle_done)     state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Stage p0: feature capture; a frame ends early (short) or overruns (long) -> err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_p0 <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else if (release_res) begin
      feat_p0 <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else if (state == LOAD && beat) begin
      for (int i = 0; i < FEAT_CNT; i++) begin
        if (cnt == CNT_W'(i)) feat_p0[i*FEAT_BITS +: FEAT_BITS] <= in_data;
      end
      cnt <= cnt + CNT_W'(1);
      if (in_last ? (cnt != LAST_IDX) : (cnt == LAST_IDX)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  settle_cnt <= '0;
    else if (state != SETTLE) settle_cnt <= '0;
    else if (!settle_done)    settle_cnt <= settle_cnt + 8'(1);
  end

  // Stage p1: result capture once the classifier has had SETTLE_CYCLES edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (settle_done) begin
      class_p1 <= prediction;
      err_p1   <= err;
    end
  end

endmodule
